store_align_unit: RTL and testbench

- Store-side counterpart of the load-extension path in the MEM stage.
- Takes a store (sb/sh/sw) from the pipeline and produces lane-aligned write data and byte enables for the word-addressed data memory.
- Stores that cross a word boundary are split into two memory beats under an FSM; the unit stalls the pipeline until the store completes.

---
 rtl/store_align_unit.sv | 215 +++++++++++++++++++++
 tb/tb_store_align_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/store_align_unit.sv
// ============================================================================
// store_align_unit : lane-aligns sb/sh/sw stores and splits word-crossing
//                    stores into two memory beats. Optional MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_align_unit #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_LATENCY_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           StoreData,
  output logic                  Stall,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
`ifdef MISALIGN_TRAP_EN
  output logic                  misaligned_trap,
`endif
  output logic                  store_done,
  output logic                  store_err
);

  localparam int CW = (MEM_LATENCY_MAX > 0) ? $clog2(MEM_LATENCY_MAX + 1) : 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(MEM_LATENCY_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic [3:0]              mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0]   b1_addr_q, b1_addr_d;
  logic [31:0]             b1_wdata_q, b1_wdata_d;
  logic [3:0]              b1_be_q, b1_be_d;
  logic                    split_q, split_d;
  logic                    stall_q, stall_d;
  logic                    store_done_q, store_done_d;
  logic                    store_err_q, store_err_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [1:0]              off;
  logic [3:0]              base_be;
  logic [31:0]             masked_data;
  logic [7:0]              be8;
  logic [63:0]             data64;
  logic                    legal;
  logic                    handshake;
  logic [CW-1:0]           cnt_inc;
  logic [ADDR_WIDTH-1:0]   beat0_addr;

`ifdef MISALIGN_TRAP_EN
  logic                    trap_q, trap_d;
  logic                    misaligned;
`endif

  always_comb begin
    off         = Addr[1:0];
    legal       = 1'b1;
    base_be     = 4'b1111;
    masked_data = StoreData;
    unique case (funct3)
      3'b000:  begin base_be = 4'b0001; masked_data = {24'b0, StoreData[7:0]};  end
      3'b001:  begin base_be = 4'b0011; masked_data = {16'b0, StoreData[15:0]}; end
      3'b010:  begin base_be = 4'b1111; masked_data = StoreData;                end
      default: legal = 1'b0;
    endcase
    be8        = {4'b0000, base_be} << off;
    data64     = {32'b0, masked_data} << {off, 3'b000};
    beat0_addr = {Addr[ADDR_WIDTH-1:2], 2'b00};
    handshake  = mem_req_q && mem_ready;
    cnt_inc    = cnt_q + CW'(1);
  end

`ifdef MISALIGN_TRAP_EN
  // sh at off=1 stays inside the word, so only off=3 is misaligned for halves
  assign misaligned = ((funct3 == 3'b001) && (off == 2'd3)) ||
                      ((funct3 == 3'b010) && (off != 2'd0));
`endif

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    b1_addr_d    = b1_addr_q;
    b1_wdata_d   = b1_wdata_q;
    b1_be_d      = b1_be_q;
    split_d      = split_q;
    cnt_d        = cnt_q;
    store_done_d = 1'b0;
    store_err_d  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap_d       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (MemWrite) begin
          if (!legal) begin
            store_err_d = 1'b1;
`ifdef MISALIGN_TRAP_EN
          end else if (misaligned) begin
            trap_d = 1'b1;
`endif
          end else begin
            mem_addr_d  = beat0_addr;
            mem_be_d    = be8[3:0];
            mem_wdata_d = data64[31:0];
            b1_addr_d   = beat0_addr + ADDR_WIDTH'(4);
            b1_be_d     = be8[7:4];
            b1_wdata_d  = data64[63:32];
            split_d     = (be8[7:4] != 4'b0000);
            mem_req_d   = 1'b1;
            cnt_d       = '0;
            state_d     = FIRST;
          end
        end
      end
      FIRST, SECOND: begin
        if (handshake) begin
          if ((state_q == FIRST) && split_q) begin
            mem_addr_d  = b1_addr_q;
            mem_be_d    = b1_be_q;
            mem_wdata_d = b1_wdata_q;
            cnt_d       = '0;
            state_d     = SECOND;
          end else begin
            mem_req_d    = 1'b0;
            store_done_d = 1'b1;
            state_d      = FINISH;
          end
        end else if ((MEM_LATENCY_MAX > 0) && (cnt_inc == C_CNT_MAX)) begin
          mem_req_d   = 1'b0;
          store_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FINISH: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      b1_addr_q    <= '0;
      b1_wdata_q   <= '0;
      b1_be_q      <= '0;
      split_q      <= 1'b0;
      stall_q      <= 1'b0;
      store_done_q <= 1'b0;
      store_err_q  <= 1'b0;
      cnt_q        <= '0;
`ifdef MISALIGN_TRAP_EN
      trap_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      b1_addr_q    <= b1_addr_d;
      b1_wdata_q   <= b1_wdata_d;
      b1_be_q      <= b1_be_d;
      split_q      <= split_d;
      stall_q      <= stall_d;
      store_done_q <= store_done_d;
      store_err_q  <= store_err_d;
      cnt_q        <= cnt_d;
`ifdef MISALIGN_TRAP_EN
      trap_q       <= trap_d;
`endif
    end
  end

  assign Stall      = stall_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign store_done = store_done_q;
  assign store_err  = store_err_q;
`ifdef MISALIGN_TRAP_EN
  assign misaligned_trap = trap_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_align_unit.sv
// ============================================================================
// tb_store_align_unit : directed self-checking bench for store_align_unit
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_store_align_unit;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        Stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        store_done;
  logic        store_err;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned_trap;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  store_align_unit #(
    .ADDR_WIDTH      (32),
    .MEM_LATENCY_MAX (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .Addr       (Addr),
    .StoreData  (StoreData),
    .Stall      (Stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
`ifdef MISALIGN_TRAP_EN
    .misaligned_trap (misaligned_trap),
`endif
    .store_done (store_done),
    .store_err  (store_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d);
    chk({tag, "_req"},   {31'b0, mem_req}, 32'd1);
    chk({tag, "_addr"},  mem_addr, a);
    chk({tag, "_be"},    {28'b0, mem_be}, {28'b0, be});
    chk({tag, "_wdata"}, mem_wdata, d);
    chk({tag, "_stall"}, {31'b0, Stall}, 32'd1);
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    funct3    = f3;
    Addr      = a;
    StoreData = d;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; funct3 = 3'b000; Addr = '0; StoreData = '0; mem_ready = 1'b0;
    step(); step();
    chk("rst_req",   {31'b0, mem_req}, 32'd0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be",    {28'b0, mem_be}, 32'h0);
    chk("rst_stall", {31'b0, Stall}, 32'd0);
    chk("rst_done",  {31'b0, store_done}, 32'd0);
    chk("rst_err",   {31'b0, store_err}, 32'd0);
    reset = 1'b0;
    step();

    // aligned sw, memory always ready
    mem_ready = 1'b1;
    drive(3'b010, 32'h100, 32'hDEADBEEF);
    step();
    beat("sw", 32'h100, 4'b1111, 32'hDEADBEEF);
    chk("sw_done0", {31'b0, store_done}, 32'd0);
    MemWrite = 1'b0;
    step();
    chk("sw_done",   {31'b0, store_done}, 32'd1);
    chk("sw_req0",   {31'b0, mem_req}, 32'd0);
    chk("sw_stallf", {31'b0, Stall}, 32'd1);
    step();
    chk("sw_idle_stall", {31'b0, Stall}, 32'd0);
    chk("sw_done_low",   {31'b0, store_done}, 32'd0);

    // sb into top lane; StoreData upper bytes must be masked off
    drive(3'b000, 32'h203, 32'h123456AB);
    step();
    beat("sb", 32'h200, 4'b1000, 32'hAB000000);
    MemWrite = 1'b0;
    step();
    chk("sb_done", {31'b0, store_done}, 32'd1);
    chk("sb_req0", {31'b0, mem_req}, 32'd0);

`ifndef MISALIGN_TRAP_EN
    // new store presented during FINISH is ignored, then accepted from IDLE
    drive(3'b010, 32'h102, 32'hAABBCCDD);
    step();
    chk("b2b_ignored_req", {31'b0, mem_req}, 32'd0);
    chk("b2b_idle_stall",  {31'b0, Stall}, 32'd0);
    step();
    MemWrite = 1'b0;
    beat("sw_split0", 32'h100, 4'b1100, 32'hCCDD0000);
    step();
    beat("sw_split1", 32'h104, 4'b0011, 32'h0000AABB);
    step();
    chk("split_done", {31'b0, store_done}, 32'd1);
    chk("split_req0", {31'b0, mem_req}, 32'd0);
    step();

    // sh crossing word, memory wait states, reset during beat 1
    mem_ready = 1'b0;
    drive(3'b001, 32'h7, 32'hFFFF1234);
    step();
    MemWrite = 1'b0;
    beat("sh_w1", 32'h4, 4'b1000, 32'h34000000);
    step();
    beat("sh_w2", 32'h4, 4'b1000, 32'h34000000);
    step();
    beat("sh_w3", 32'h4, 4'b1000, 32'h34000000);
    step();
    beat("sh_w4", 32'h4, 4'b1000, 32'h34000000);
    mem_ready = 1'b1;
    step();
    beat("sh_b1", 32'h8, 4'b0001, 32'h00000012);
    reset = 1'b1;
    step();
    chk("rstmid_req",   {31'b0, mem_req}, 32'd0);
    chk("rstmid_stall", {31'b0, Stall}, 32'd0);
    chk("rstmid_done",  {31'b0, store_done}, 32'd0);
    reset = 1'b0;
    step();
    chk("rstmid_req2",  {31'b0, mem_req}, 32'd0);
    chk("rstmid_done2", {31'b0, store_done}, 32'd0);

    // beat-1 address wraps modulo 2^32
    drive(3'b010, 32'hFFFFFFFE, 32'h01020304);
    step();
    MemWrite = 1'b0;
    beat("wrap0", 32'hFFFFFFFC, 4'b1100, 32'h03040000);
    step();
    beat("wrap1", 32'h00000000, 4'b0011, 32'h00000102);
    step();
    chk("wrap_done", {31'b0, store_done}, 32'd1);
    step();
`else
    // misaligned sw traps without touching memory
    drive(3'b010, 32'h101, 32'h11111111);
    step();
    MemWrite = 1'b0;
    chk("trap_pulse", {31'b0, misaligned_trap}, 32'd1);
    chk("trap_stall", {31'b0, Stall}, 32'd0);
    chk("trap_req",   {31'b0, mem_req}, 32'd0);
    step();
    chk("trap_low",   {31'b0, misaligned_trap}, 32'd0);
    chk("trap_req2",  {31'b0, mem_req}, 32'd0);
`endif

    // illegal funct3
    mem_ready = 1'b1;
    drive(3'b011, 32'h400, 32'h55555555);
    step();
    MemWrite = 1'b0;
    chk("ill_err",   {31'b0, store_err}, 32'd1);
    chk("ill_req",   {31'b0, mem_req}, 32'd0);
    chk("ill_stall", {31'b0, Stall}, 32'd0);
    step();
    chk("ill_err_low", {31'b0, store_err}, 32'd0);
    chk("ill_req2",    {31'b0, mem_req}, 32'd0);

    // timeout with MEM_LATENCY_MAX=4 and memory never ready
    mem_ready = 1'b0;
    drive(3'b010, 32'h300, 32'h11223344);
    step();
    MemWrite = 1'b0;
    beat("to_c1", 32'h300, 4'b1111, 32'h11223344);
    step(); step(); step();
    chk("to_c4_req", {31'b0, mem_req}, 32'd1);
    chk("to_c4_err", {31'b0, store_err}, 32'd0);
    step();
    chk("to_err",   {31'b0, store_err}, 32'd1);
    chk("to_req0",  {31'b0, mem_req}, 32'd0);
    chk("to_stall", {31'b0, Stall}, 32'd0);
    chk("to_done",  {31'b0, store_done}, 32'd0);
    step();
    chk("to_err_low", {31'b0, store_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
